// File: rtl/detect_sched_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : detect_sched_if
// Purpose  : Bundles the requester-side job bus and the result outputs of
//            detect_sched.
// Signals  : req      N_REQ        per-requester job request (level)
//            data     N_REQ*WIDTH  job words, requester k at [k*WIDTH +: WIDTH]
//            gnt      N_REQ        one-hot grant pulse
//            busy     1            job in progress
//            done     1            result-valid pulse
//            done_id  ID_W         index of the served requester
//            run_len  LEN_W        length of the first run of ones
//            locked   1            a 0 terminated the first run
// Modports : master (requester side), slave (scheduler side)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface detect_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int ID_W  = 2
) ();
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] data;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [LEN_W-1:0]       run_len;
    logic                   locked;

    modport master (
        output req, data,
        input  gnt, busy, done, done_id, run_len, locked
    );

    modport slave (
        input  req, data,
        output gnt, busy, done, done_id, run_len, locked
    );
endinterface
`default_nettype wire

// File: rtl/detect_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : detect_sched
// Purpose  : Round-robin scheduler sharing one serial run-detector among
//            N_REQ requesters. The granted word is shifted MSB-first through
//            the detector; the length of the first run of ones and whether a
//            0 terminated it (locked) are reported with a done pulse.
// Ports    : clk    - clock, rising edge
//            reset  - asynchronous active-low reset
//            bus    - detect_sched_if.slave (req/data in; gnt, busy, done,
//                     done_id, run_len, locked out)
// Options  : DETECT_SCHED_EARLY_LOCK_EN - when defined, the job ends as soon
//            as the detector locks; remaining bits are discarded.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module detect_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int ID_W  = 2
) (
    input  wire logic      clk,
    input  wire logic      reset,
    detect_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ONES = 2'd1,
        D_LOCK = 2'd2
    } det_state_t;

    ctrl_state_t        r_state;
    det_state_t         r_det;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_win;
    logic [WIDTH-1:0]   r_sr;
    logic [LEN_W-1:0]   r_bitcnt;
    logic [LEN_W-1:0]   r_runcnt;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_busy;
    logic               r_done;
    logic [ID_W-1:0]    r_done_id;
    logic [LEN_W-1:0]   r_run_len;
    logic               r_locked;

    logic               w_found;
    int                 w_win_int;
    logic [N_REQ-1:0]   w_onehot;
    logic               w_x;
    logic               w_last_bit;
    logic               w_early;
    logic [ID_W-1:0]    w_ptr_next;

    // Rotating priority search: first set request at or above r_ptr, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_win_int = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && bus.req[(int'(r_ptr) + i) % N_REQ]) begin
                w_found   = 1'b1;
                w_win_int = (int'(r_ptr) + i) % N_REQ;
            end
        end
        w_onehot = N_REQ'(1) << w_win_int;
    end

    assign w_x        = r_sr[WIDTH-1];
    assign w_last_bit = (r_bitcnt == LEN_W'(WIDTH - 1));
    assign w_ptr_next = (r_win == ID_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;

`ifdef DETECT_SCHED_EARLY_LOCK_EN
    // The edge that feeds the terminating 0 is the one that enters D_LOCK.
    assign w_early = (r_det == D_ONES) && !w_x;
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_det     <= D_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_sr      <= '0;
            r_bitcnt  <= '0;
            r_runcnt  <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_run_len <= '0;
            r_locked  <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sr     <= bus.data[w_win_int*WIDTH +: WIDTH];
                        r_gnt    <= w_onehot;
                        r_win    <= ID_W'(w_win_int);
                        r_det    <= D_IDLE;
                        r_bitcnt <= '0;
                        r_runcnt <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sr     <= {r_sr[WIDTH-2:0], 1'b0};
                    r_bitcnt <= r_bitcnt + 1'b1;
                    case (r_det)
                        D_IDLE: begin
                            if (w_x) begin
                                r_det    <= D_ONES;
                                r_runcnt <= r_runcnt + 1'b1;
                            end
                        end
                        D_ONES: begin
                            if (w_x) begin
                                r_runcnt <= r_runcnt + 1'b1;
                            end else begin
                                r_det <= D_LOCK;
                            end
                        end
                        default: begin
                            // D_LOCK absorbs every further bit.
                        end
                    endcase
                    if (w_last_bit || w_early) begin
                        r_state <= REPORT;
                    end
                end
                REPORT: begin
                    r_done    <= 1'b1;
                    r_done_id <= r_win;
                    r_run_len <= r_runcnt;
                    r_locked  <= (r_det == D_LOCK);
                    r_busy    <= 1'b0;
                    r_ptr     <= w_ptr_next;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.run_len = r_run_len;
    assign bus.locked  = r_locked;

endmodule
`default_nettype wire
